// File: rtl/rec_pkg.sv
// Shared types and defaults for the fault-recovery sequencer.
// The FSM state encoding is shared so that integration code can decode it.
package rec_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        RECOVER = 3'd2,
        RETRY   = 3'd3,
        FATAL   = 3'd4
    } state_t;

endpackage

// File: rtl/rec_checkpoint_reg.sv
// Architectural checkpoint register.
// Holds the last known-good next-PC and captures a new value only when load is high.
module rec_checkpoint_reg #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/recovery_controller.sv
// Fault-recovery sequencer: checkpoints commits, flushes on a fault, pulses
// recovery, monitors the retry and escalates to a sticky fatal state.
module recovery_controller
    import rec_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter int               FLUSH_CYCLES = 3,
    parameter int               MAX_RETRY    = 3,
    parameter logic [XLEN-1:0]  RESET_PC     = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fault_detected,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_next_pc,
    output logic            recovery_en,
    output logic [XLEN-1:0] pc_saved,
    output logic            flush,
    output logic            stall,
    output logic [2:0]      retry_count,
    output logic            fatal_error
);

    localparam int              CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [2:0]      RETRY_LIMIT = 3'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic             ckpt_load;

    rec_checkpoint_reg #(
        .XLEN      (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_checkpoint (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ckpt_load),
        .d     (commit_next_pc),
        .q     (pc_saved)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            retry_q     <= retry_d;
        end
    end

    // Fault always takes priority over a same-cycle commit so a possibly
    // corrupted next-PC never reaches the checkpoint.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        retry_d     = retry_q;
        ckpt_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fault_detected) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (commit_valid) begin
                    ckpt_load = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = RECOVER;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                state_d = RETRY;
                if (retry_q != 3'd7) begin
                    retry_d = retry_q + 3'd1;
                end
            end
            RETRY: begin
                if (fault_detected) begin
                    if (retry_q >= RETRY_LIMIT) begin
                        state_d = FATAL;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end else if (commit_valid) begin
                    state_d   = IDLE;
                    retry_d   = '0;
                    ckpt_load = 1'b1;
                end
            end
            FATAL: begin
                state_d = FATAL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode keeps every output free of input-to-output paths.
    always_comb begin
        recovery_en = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        fatal_error = 1'b0;
        case (state_q)
            FLUSH: begin
                flush = 1'b1;
                stall = 1'b1;
            end
            RECOVER: begin
                recovery_en = 1'b1;
                stall       = 1'b1;
            end
            FATAL: begin
                fatal_error = 1'b1;
                flush       = 1'b1;
                stall       = 1'b1;
            end
            default: ;
        endcase
    end

    assign retry_count = retry_q;

endmodule

// File: tb/tb_recovery_controller.sv
// Scoreboard bench for recovery_controller with a cycle-level reference model
// and randomized fault/commit traffic.
module tb_recovery_controller;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 3;
    localparam int MAX_RETRY    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        rec_en;
        logic        flush;
        logic        stall;
        logic [2:0]  retry;
        logic        fatal;
        logic [31:0] pc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fault_detected = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_next_pc = '0;
    logic        recovery_en;
    logic [31:0] pc_saved;
    logic        flush;
    logic        stall;
    logic [2:0]  retry_count;
    logic        fatal_error;

    int vectors = 0;
    int miscompares = 0;

    obs_t sb_q[$];
    obs_t act;

    recovery_controller #(
        .XLEN         (XLEN),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MAX_RETRY    (MAX_RETRY),
        .RESET_PC     (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fault_detected (fault_detected),
        .commit_valid   (commit_valid),
        .commit_next_pc (commit_next_pc),
        .recovery_en    (recovery_en),
        .pc_saved       (pc_saved),
        .flush          (flush),
        .stall          (stall),
        .retry_count    (retry_count),
        .fatal_error    (fatal_error)
    );

    always #5 clk = ~clk;

    assign act = '{rec_en: recovery_en, flush: flush, stall: stall,
                   retry: retry_count, fatal: fatal_error, pc: pc_saved};

    // Reference model: remaining flush cycles, a pending recovery pulse,
    // whether we are watching a retry, and the sticky fatal flag.
    int          m_flush_left;
    bit          m_pulse;
    bit          m_retrying;
    bit          m_fatal;
    int          m_retries;
    logic [31:0] m_pc;

    function automatic obs_t model_obs();
        obs_t o;
        o.rec_en = m_pulse;
        o.flush  = (m_flush_left > 0) || m_fatal;
        o.stall  = (m_flush_left > 0) || m_fatal || m_pulse;
        o.retry  = 3'(m_retries);
        o.fatal  = m_fatal;
        o.pc     = m_pc;
        return o;
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_pulse      = 0;
        m_retrying   = 0;
        m_fatal      = 0;
        m_retries    = 0;
        m_pc         = RESET_PC;
    endtask

    task automatic model_step(input bit f, input bit c, input logic [31:0] p);
        if (m_fatal) begin
            return;
        end
        if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_pulse = 1;
        end else if (m_pulse) begin
            m_pulse    = 0;
            m_retries  = (m_retries < 7) ? m_retries + 1 : 7;
            m_retrying = 1;
        end else if (f) begin
            if (m_retrying && m_retries >= MAX_RETRY) m_fatal = 1;
            else m_flush_left = FLUSH_CYCLES;
        end else if (c) begin
            m_pc = p;
            if (m_retrying) begin
                m_retrying = 0;
                m_retries  = 0;
            end
        end
    endtask

    task automatic check(input string name, input obs_t e);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got rec_en=%b flush=%b stall=%b retry=%0d fatal=%b pc=%h, expected rec_en=%b flush=%b stall=%b retry=%0d fatal=%b pc=%h",
                     name, $time, act.rec_en, act.flush, act.stall, act.retry, act.fatal, act.pc,
                     e.rec_en, e.flush, e.stall, e.retry, e.fatal, e.pc);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered result, pop its expectation.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            check("cycle", sb_q.pop_front());
        end
    end

    task automatic step(input bit f, input bit c, input logic [31:0] p);
        @(negedge clk);
        fault_detected = f;
        commit_valid   = c;
        commit_next_pc = p;
        model_step(f, c, p);
        sb_q.push_back(model_obs());
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        fault_detected = 1'b0;
        commit_valid   = 1'b0;
        #1;
        model_reset();
        check(name, model_obs());
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check("reset_state", model_obs());
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Checkpoint updates on clean commits
        step(0, 1, 32'h10);
        step(0, 1, 32'h14);
        step(0, 1, 32'h18);
        step(0, 0, 32'h0);

        // Single fault, clean retry
        step(1, 0, 32'h0);
        repeat (FLUSH_CYCLES + 1) step(0, 0, 32'h0);
        step(0, 1, 32'h1C);
        step(0, 0, 32'h0);

        // Fault with simultaneous commit; faults during flush ignored
        step(1, 1, 32'h40);
        repeat (FLUSH_CYCLES) step(1, 1, 32'h50);
        step(1, 0, 32'h0);
        step(0, 1, 32'h44);
        step(0, 0, 32'h0);

        // Escalation to fatal, then commits must not release it
        repeat (20) step(1, 0, 32'h0);
        repeat (25) step(0, 1, $urandom & 32'hFFFF_FFFC);
        async_reset("reset_in_fatal");

        // Reset in the middle of a flush
        step(0, 1, 32'h100);
        step(1, 0, 32'h0);
        step(0, 0, 32'h0);
        async_reset("reset_in_flush");
        step(0, 0, 32'h0);

        // Randomized traffic with occasional bursts of faults and resets
        for (int i = 0; i < 3000; i++) begin
            bit f;
            bit c;
            if ((i % 500) < 60) f = ($urandom_range(0, 2) == 0);
            else f = ($urandom_range(0, 7) == 0);
            c = 1'($urandom_range(0, 1));
            step(f, c, $urandom & 32'hFFFF_FFFC);
            if ((i % 400) == 399) async_reset("reset_random");
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
